div_unit: RTL and testbench

- Multi-cycle 32-bit integer divider for DIV/DIVU, attached directly to the EX stage.
- EX issues operands and a start pulse, and holds stallreq high until ready_o is seen.
- The {remainder, quotient} result returns to EX, which forwards it as hi/lo for the HI/LO write path through EX/MEM, MEM/WB and hilo_reg.
- Radix-2 restoring algorithm: one quotient bit per cycle.

---
 rtl/div_unit_pkg.sv | 16 +
 rtl/div_unit_step.sv | 17 +
 rtl/div_unit.sv | 89 ++++++++
 tb/tb_div_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared constants and state encodings for the multi-cycle divider.
package div_unit_pkg;
    localparam int DATA_W = 32;
    localparam int CNT_W = 6;
    localparam logic [DATA_W-1:0] ZeroWord = '0;
    localparam logic DivResultReady = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart = 1'b1;
    localparam logic DivStop = 1'b0;
    typedef enum logic [1:0] {
        DivFree = 2'd0,
        DivByZero = 2'd1,
        DivOn = 2'd2,
        DivEnd = 2'd3
    } div_state_t;
endpackage

// File: rtl/div_unit_step.sv
// div_unit_step: one restoring-division iteration (trial subtract, then shift in a quotient bit).
module div_unit_step
    import div_unit_pkg::*;
(
    input  logic [2*DATA_W:0]  work,
    input  logic [DATA_W-1:0]  divisor,
    output logic [2*DATA_W:0]  next
);
    logic borrow;
    logic [DATA_W-1:0] diff;
    // Without a borrow the difference is below the divisor, so 32 bits suffice.
    always_comb begin
        borrow = work[2*DATA_W:DATA_W] < {1'b0, divisor};
        diff = work[2*DATA_W-1:DATA_W] - divisor;
        next = borrow ? {work[2*DATA_W-1:0], 1'b0} : {diff, work[DATA_W-1:0], 1'b1};
    end
endmodule

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring DIV/DIVU unit for the EX stage.
// result_o = {remainder, quotient}; remainder sign follows the dividend.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);
    div_state_t state;
    logic [CNT_W-1:0] cnt;
    logic [2*DATA_W:0] work, step;
    logic [DATA_W-1:0] divisor, abs1, abs2, quo, rem;
    logic sgn, neg1, neg2;

    div_unit_step u_step (.work(work), .divisor(divisor), .next(step));

    always_comb begin
        abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        quo = (sgn && (neg1 ^ neg2)) ? -work[DATA_W-1:0] : work[DATA_W-1:0];
        rem = (sgn && neg1) ? -work[2*DATA_W:DATA_W+1] : work[2*DATA_W:DATA_W+1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DivFree;
            cnt <= '0;
            work <= '0;
            divisor <= ZeroWord;
            sgn <= 1'b0;
            neg1 <= 1'b0;
            neg2 <= 1'b0;
            result_o <= '0;
            ready_o <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    ready_o <= DivResultNotReady;
                    result_o <= '0;
                    if (start_i == DivStart && !annul_i) begin
                        state <= (opdata2_i == ZeroWord) ? DivByZero : DivOn;
                        cnt <= '0;
                        work <= {ZeroWord, abs1, 1'b0};
                        divisor <= abs2;
                        sgn <= signed_div_i;
                        neg1 <= opdata1_i[DATA_W-1];
                        neg2 <= opdata2_i[DATA_W-1];
                    end
                end
                DivByZero: begin
                    work <= '0;
                    state <= DivEnd;
                end
                DivOn: begin
                    if (annul_i) begin
                        state <= DivFree;
                        cnt <= '0;
                    end else if (cnt != CNT_W'(DATA_W)) begin
                        work <= step;
                        cnt <= cnt + 1'b1;
                    end else begin
                        // Final result parked in work; bit DATA_W is a don't-care gap.
                        work <= {rem, 1'b0, quo};
                        cnt <= '0;
                        state <= DivEnd;
                    end
                end
                DivEnd: begin
                    if (annul_i || start_i == DivStop) begin
                        state <= DivFree;
                        ready_o <= DivResultNotReady;
                        result_o <= '0;
                    end else begin
                        ready_o <= DivResultReady;
                        result_o <= {work[2*DATA_W:DATA_W+1], work[DATA_W-1:0]};
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with directed, hand-computed vectors.
module tb_div_unit;
    logic clk, rst, signed_div_i, start_i, annul_i, ready_o;
    logic [31:0] opdata1_i, opdata2_i;
    logic [63:0] result_o;

    typedef struct {
        logic [63:0] res;
        int lat;
    } exp_t;

    exp_t sb[$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic prev_ready = 1'b0;

    div_unit dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every rising ready_o must match the oldest expected response.
    always @(negedge clk) begin
        if (ready_o && !prev_ready) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_ready: result %h with no pending request", result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                compared++;
                if (result_o !== e.res) begin
                    mismatched++;
                    $display("FAIL result: got %h expected %h", result_o, e.res);
                end
                compared++;
                if (cyc - start_cyc != e.lat) begin
                    mismatched++;
                    $display("FAIL latency: got %0d expected %0d", cyc - start_cyc, e.lat);
                end
            end
        end
        prev_ready <= ready_o;
    end

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i = a;
        opdata2_i = b;
        start_i = 1'b1;
        start_cyc = cyc + 1;
    endtask

    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input bit rst_end);
        int k;
        exp_t e;
        issue(sgn, a, b);
        e.res = exp;
        e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_div_i = ~sgn;
        k = 0;
        while (!ready_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!ready_o) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: ready_o %b expected 1 within 100 cycles", ready_o);
            if (sb.size() != 0) void'(sb.pop_back());
            start_i = 1'b0;
            @(negedge clk);
        end else if (rst_end) begin
            #2 rst = 1'b0;
            #1 check("async_rst_end", {ready_o, result_o}, 65'd0);
            start_i = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
        end else begin
            @(negedge clk);
            check("hold", {ready_o, result_o}, {1'b1, exp});
            start_i = 1'b0;
            @(negedge clk);
            check("release", {ready_o, result_o}, 65'd0);
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        start_i = 1'b0;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        #1 rst = 1'b0;
        #1 check("reset", {ready_o, result_o}, 65'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 0);
        run_op(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0);
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 34, 0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, 0);
        run_op(1'b0, 32'hFFFFFFFF, 32'h1, {32'h0, 32'hFFFFFFFF}, 34, 0);
        run_op(1'b0, 32'd5, 32'd0, 64'd0, 2, 0);
        run_op(1'b1, 32'd0, 32'd3, 64'd0, 34, 0);
        run_op(1'b0, 32'hFFFFFFFF, 32'h80000000, {32'h7FFFFFFF, 32'h1}, 34, 0);
        run_op(1'b0, 32'h87654321, 32'h10, {32'h1, 32'h08765432}, 34, 0);
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, {32'h1, 32'h1}, 34, 0);

        // Annul at N+10: the operation must vanish without ever raising ready_o.
        issue(1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
        end
        check("annul_no_ready", {64'd0, seen}, 65'd0);
        run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 0);

        // Reset mid-division, then reset while a result is being presented.
        issue(1'b0, 32'd100, 32'd7);
        repeat (21) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_rst_on", {ready_o, result_o}, 65'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 1);
        run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 65'(sb.size()), 65'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end
endmodule
